pool2x2_act_stream: RTL and testbench

- Parametrised next-generation 2x2 stride-2 pooling plus activation stage for the CNN datapath; sits directly after the convolution/adder-tree outputs.
- Accepts a raster-order stream of CH signed channels per pixel and emits one pooled pixel per 2x2 window.
- Adds over the previous generation: runtime max/average pooling select, optional ReLU bypass, arbitrary channel count, explicit row/column tracking and an end-of-frame pulse.

---
 rtl/pool2x2_act_stream.sv | 107 ++++++++++
 tb/tb_pool2x2_act_stream.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pool2x2_act_stream.sv
// 2x2 stride-2 pooling (max or average) with optional ReLU over a raster-order
// stream of CH signed channels per pixel; one output pixel per completed window.
module pool2x2_act_stream #(
    parameter int DATA_W    = 12,
    parameter int CH        = 3,
    parameter int IN_WIDTH  = 24,
    parameter int IN_HEIGHT = 24,
    parameter int COL_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [CH*DATA_W-1:0] data_in,
    input  logic                 pool_mode,
    input  logic                 relu_en,
    output logic [CH*DATA_W-1:0] data_out,
    output logic                 valid_out,
    output logic                 frame_done
);

    localparam int HALF  = IN_WIDTH / 2;
    localparam int PW    = DATA_W + 2;
    localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);
    localparam logic [COL_W-1:0] ROW_LAST = COL_W'(IN_HEIGHT - 1);

    logic [COL_W-1:0]     col;
    logic [COL_W-1:0]     row;
    logic                 avg_q;
    logic                 relu_q;
    logic [IDX_W-1:0]     idx;
    logic                 first_pix;
    logic                 win_end;
    logic                 frame_end;
    logic signed [PW-1:0] lbuf  [CH][HALF];
    logic signed [PW-1:0] x_ext [CH];
    logic signed [PW-1:0] comb  [CH];
    logic signed [PW-1:0] fin   [CH];
    logic [CH*DATA_W-1:0] result;

    assign idx       = col[IDX_W:1];
    assign first_pix = (col == '0) && (row == '0);
    assign win_end   = row[0] && col[0];
    assign frame_end = win_end && (col == COL_LAST) && (row == ROW_LAST);

    // Per-lane combine of the stored window partial with the incoming sample,
    // then finalisation (average divide and ReLU) for the window-closing pixel.
    always_comb begin
        result = '0;
        for (int k = 0; k < CH; k++) begin
            x_ext[k] = {{2{data_in[k*DATA_W + DATA_W - 1]}}, data_in[k*DATA_W +: DATA_W]};
            if (avg_q) begin
                comb[k] = lbuf[k][idx] + x_ext[k];
                fin[k]  = comb[k] >>> 2;
            end else begin
                comb[k] = (x_ext[k] > lbuf[k][idx]) ? x_ext[k] : lbuf[k][idx];
                fin[k]  = comb[k];
            end
            if (relu_q && fin[k] < 0) begin
                fin[k] = '0;
            end
            result[k*DATA_W +: DATA_W] = fin[k][DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            avg_q      <= 1'b0;
            relu_q     <= 1'b0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            data_out   <= '0;
        end else begin
            valid_out  <= valid_in && win_end;
            frame_done <= valid_in && frame_end;
            if (valid_in) begin
                // Modes only change at a frame boundary so a frame is never mixed.
                if (first_pix) begin
                    avg_q  <= pool_mode;
                    relu_q <= relu_en;
                end
                if (win_end) begin
                    data_out <= result;
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // The line buffer is deliberately not reset: the (0,0) pixel of every
    // window overwrites its entry before any combine reads it.
    always_ff @(posedge clk) begin
        if (valid_in && !win_end) begin
            for (int k = 0; k < CH; k++) begin
                lbuf[k][idx] <= (row[0] || col[0]) ? comb[k] : x_ext[k];
            end
        end
    end

endmodule

// File: tb/tb_pool2x2_act_stream.sv
// Directed bench for pool2x2_act_stream on a 4x4 two-channel frame.
module tb_pool2x2_act_stream;

    localparam int DATA_W = 12;
    localparam int CH     = 2;

    logic                 clk;
    logic                 rst_n;
    logic                 valid_in;
    logic [CH*DATA_W-1:0] data_in;
    logic                 pool_mode;
    logic                 relu_en;
    logic [CH*DATA_W-1:0] data_out;
    logic                 valid_out;
    logic                 frame_done;

    int tests;
    int fails;

    logic signed [DATA_W-1:0] pix0 [16];
    logic signed [DATA_W-1:0] pix1 [16];
    logic signed [DATA_W-1:0] exp0 [4];
    logic signed [DATA_W-1:0] exp1 [4];

    pool2x2_act_stream #(
        .DATA_W(DATA_W), .CH(CH), .IN_WIDTH(4), .IN_HEIGHT(4), .COL_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .pool_mode(pool_mode), .relu_en(relu_en), .data_out(data_out),
        .valid_out(valid_out), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) begin
            pix0[i] = DATA_W'(i + 1);
            pix1[i] = -DATA_W'(i + 1);
        end
    endtask

    task automatic set_win(input int w, input int ch, input int a, input int b, input int c, input int d);
        int base;
        base = (w / 2) * 8 + (w % 2) * 2;
        if (ch == 0) begin
            pix0[base] = DATA_W'(a); pix0[base + 1] = DATA_W'(b);
            pix0[base + 4] = DATA_W'(c); pix0[base + 5] = DATA_W'(d);
        end else begin
            pix1[base] = DATA_W'(a); pix1[base + 1] = DATA_W'(b);
            pix1[base + 4] = DATA_W'(c); pix1[base + 5] = DATA_W'(d);
        end
    endtask

    task automatic set_exp(input int a0, input int b0, input int c0, input int d0,
                           input int a1, input int b1, input int c1, input int d1);
        exp0[0] = DATA_W'(a0); exp0[1] = DATA_W'(b0); exp0[2] = DATA_W'(c0); exp0[3] = DATA_W'(d0);
        exp1[0] = DATA_W'(a1); exp1[1] = DATA_W'(b1); exp1[2] = DATA_W'(c1); exp1[3] = DATA_W'(d1);
    endtask

    task automatic apply_stimulus(input int i, input logic pm, input logic re);
        pool_mode = pm;
        relu_en   = re;
        valid_in  = 1'b1;
        data_in   = {pix1[i], pix0[i]};
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
    endtask

    // Sends one frame; pool_mode switches from pm_first to pm_after at switch_idx.
    task automatic run_frame(input logic pm_first, input logic pm_after, input int switch_idx,
                             input logic re, input int max_gap);
        int w;
        int n;
        logic [31:0] held;
        w = 0;
        held = '0;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(i, (i < switch_idx) ? pm_first : pm_after, re);
            if ((i / 4) % 2 == 1 && (i % 4) % 2 == 1) begin
                held = {8'h0, exp1[w], exp0[w]};
                check_output($sformatf("win%0d_valid", w), {31'h0, valid_out}, 32'd1);
                check_output($sformatf("win%0d_data", w), {8'h0, data_out}, held);
                check_output($sformatf("win%0d_done", w), {31'h0, frame_done}, (w == 3) ? 32'd1 : 32'd0);
                w++;
            end else begin
                check_output($sformatf("pix%0d_valid", i), {31'h0, valid_out}, 32'd0);
                check_output($sformatf("pix%0d_done", i), {31'h0, frame_done}, 32'd0);
            end
            n = $urandom_range(0, max_gap);
            repeat (n) begin
                @(posedge clk);
                #1;
                check_output("bubble_valid", {31'h0, valid_out}, 32'd0);
                check_output("bubble_done", {31'h0, frame_done}, 32'd0);
                if (w > 0) check_output("bubble_hold", {8'h0, data_out}, held);
            end
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        data_in   = '0;
        pool_mode = 1'b0;
        relu_en   = 1'b0;
        #23 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("reset_valid", {31'h0, valid_out}, 32'd0);
        check_output("reset_done", {31'h0, frame_done}, 32'd0);
        check_output("reset_data", {8'h0, data_out}, 32'd0);

        // Max with ReLU: negative channel clamps to zero
        load_ramp();
        set_exp(6, 8, 14, 16, 0, 0, 0, 0);
        run_frame(1'b0, 1'b0, 16, 1'b1, 0);

        // Max without ReLU
        set_exp(6, 8, 14, 16, -1, -3, -9, -11);
        run_frame(1'b0, 1'b0, 16, 1'b0, 0);

        // Average: floor rounding, uniform window and full-scale extremes
        set_win(0, 0, -1, -2, -2, -2);          set_win(0, 1, -5, -5, -5, -6);
        set_win(1, 0, 3, 3, 3, 4);              set_win(1, 1, 0, 0, 0, -1);
        set_win(2, 0, -2048, -2048, -2048, -2048); set_win(2, 1, 2047, 2047, 2047, 2047);
        set_win(3, 0, 7, 0, 0, 0);              set_win(3, 1, -2048, -2048, -2048, -2048);
        set_exp(-2, 3, -2048, 1, -6, -1, 2047, -2048);
        run_frame(1'b1, 1'b1, 16, 1'b0, 0);

        // Gapped valid, max with ReLU
        load_ramp();
        set_exp(6, 8, 14, 16, 0, 0, 0, 0);
        run_frame(1'b0, 1'b0, 16, 1'b1, 3);

        // Mid-frame switch to average is ignored until the next frame
        set_exp(6, 8, 14, 16, -1, -3, -9, -11);
        run_frame(1'b0, 1'b1, 5, 1'b0, 0);
        for (int i = 0; i < 16; i++) begin
            pix0[i] = 12'sd5;
            pix1[i] = 12'sd5;
        end
        set_exp(5, 5, 5, 5, 5, 5, 5, 5);
        run_frame(1'b1, 1'b1, 16, 1'b0, 0);
        load_ramp();
        set_exp(3, 5, 11, 13, -4, -6, -12, -14);
        run_frame(1'b1, 1'b1, 16, 1'b0, 1);

        // Reset after 7 pixels of an average frame, then a clean max+ReLU frame
        for (int i = 0; i < 7; i++) apply_stimulus(i, 1'b1, 1'b0);
        check_output("pre_reset_data", {8'h0, data_out}, {8'h0, -12'sd4, 12'sd3});
        #2 rst_n = 1'b0;
        #1;
        check_output("async_reset_data", {8'h0, data_out}, 32'd0);
        check_output("async_reset_valid", {31'h0, valid_out}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("post_reset_data", {8'h0, data_out}, 32'd0);
        set_exp(6, 8, 14, 16, 0, 0, 0, 0);
        run_frame(1'b0, 1'b0, 16, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
